// File: rtl/sort_frame_loader.sv
// Collects NUM_VALS words from a valid/ready stream into one packed frame for the
// sorter's A input; flush closes a partial frame, and unused slots keep PAD_VAL.
module sort_frame_loader #(
  parameter int                NUM_VALS = 8,
  parameter int                WIDTH    = 4,
  parameter logic [WIDTH-1:0]  PAD_VAL  = {WIDTH{1'b0}}
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_VALS*WIDTH-1:0]         out_frame,
  output logic [$clog2(NUM_VALS+1)-1:0]     out_count
);

  localparam int CW   = $clog2(NUM_VALS + 1);
  localparam int CNTW = $clog2(NUM_VALS);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]      state;
  logic [CNTW-1:0] cnt;
  logic [WIDTH-1:0] slots [NUM_VALS];

  logic accept;
  logic last;
  logic close;

  // in_ready comes from the state register alone, never from out_ready.
  assign in_ready = (state == FILL);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == CNTW'(NUM_VALS - 1));
  // Empty frames are never emitted: a flush alone needs at least one stored word.
  assign close    = in_ready & ((accept & (last | flush)) |
                                (flush & (cnt != {CNTW{1'b0}})));

  // Fill/hold sequencing, slot storage and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= {CNTW{1'b0}};
      out_valid <= 1'b0;
      out_count <= {CW{1'b0}};
      for (int i = 0; i < NUM_VALS; i++) begin
        slots[i] <= PAD_VAL;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            slots[cnt] <= in_data;
          end
          if (close) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= CW'(cnt) + {{(CW-1){1'b0}}, accept};
            cnt       <= {CNTW{1'b0}};
          end else if (accept) begin
            cnt <= cnt + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          // out_valid is always high here, so out_ready alone completes the handshake.
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_count <= {CW{1'b0}};
            for (int i = 0; i < NUM_VALS; i++) begin
              slots[i] <= PAD_VAL;
            end
          end
        end
        default: begin
          state     <= FILL;
          cnt       <= {CNTW{1'b0}};
          out_valid <= 1'b0;
          out_count <= {CW{1'b0}};
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VALS; g++) begin : g_pack
    assign out_frame[g*WIDTH +: WIDTH] = slots[g];
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed and randomized checks of sort_frame_loader against a word-queue model.
module tb_sort_frame_loader;

  localparam int N = 8;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_frame;
  logic [3:0]       out_count;

  int errors = 0;
  int checks = 0;

  sort_frame_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic fl);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Ascending sort of the packed words, slot 0 smallest: what the sorter would output.
  function automatic logic [N*W-1:0] sorted(input logic [N*W-1:0] f);
    int v [N];
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) v[i] = int'(f[i*W +: W]);
    v.sort();
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  // Random-phase model: words of the open frame plus a held/not-held flag.
  logic [W-1:0]   m_words [$];
  bit             m_hold;
  logic [N*W-1:0] m_frame;
  logic [N*W-1:0] prev_frame;
  bit             prev_stall;
  int             frames;
  int             cycles;

  initial begin
    logic [W-1:0] seq1 [8];
    seq1 = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {28'd0, out_count}, 32'd0);
    chk("rst_frame", out_frame, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full frame, back-to-back with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = seq1[i];
      tick();
      if (i == 6) chk("full_not_yet", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_frame", out_frame, 32'h62951413);
    chk("full_count", {28'd0, out_count}, 32'd8);
    chk("full_sorted", sorted(out_frame), 32'h96543211);
    tick();
    out_ready = 1'b0;
    chk("full_release", {31'd0, out_valid}, 32'd0);
    chk("full_pad", out_frame, 32'h0);

    // Backpressure: frame stays put, in_ready low, pending word not taken.
    for (int i = 0; i < 8; i++) send(W'(i + 1), 1'b0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_data  = 4'hA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_frame", out_frame, 32'h87654321);
      chk("bp_held", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("bp_slot0", out_frame, 32'h0000000A);
    chk("bp_count", {28'd0, out_count}, 32'd1);
    release_frame();

    // Flush of a partial frame, then a flush with nothing stored.
    send(4'd7, 1'b0); send(4'd2, 1'b0); send(4'd5, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_count", {28'd0, out_count}, 32'd3);
    chk("flush_frame", out_frame, 32'h00000527);
    release_frame();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_empty", {31'd0, out_valid}, 32'd0);

    // Flush together with an accept.
    send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b1);
    chk("fa_count", {28'd0, out_count}, 32'd3);
    chk("fa_frame", out_frame, 32'h00000CBA);
    release_frame();

    // Flush on the final word equals a normal full frame.
    for (int i = 0; i < 8; i++) send(W'(15 - i), i == 7);
    chk("flast_count", {28'd0, out_count}, 32'd8);
    chk("flast_frame", out_frame, 32'h89ABCDEF);
    release_frame();

    // Reset mid-frame discards the partial frame at once.
    for (int i = 0; i < 4; i++) send(4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_frame", out_frame, 32'h0);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(W'(8 + i), 1'b0);
    chk("mr_new_frame", out_frame, 32'hFEDCBA98);
    chk("mr_new_count", {28'd0, out_count}, 32'd8);
    release_frame();

    // Random traffic against the queue model.
    m_words.delete();
    m_hold = 1'b0;
    prev_stall = 1'b0;
    prev_frame = '0;
    frames = 0;
    cycles = 0;
    while (frames < 1000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      m_frame = '0;
      foreach (m_words[i]) m_frame[i*W +: W] = m_words[i];
      chk("rnd_ready", {31'd0, in_ready}, {31'd0, !m_hold});
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_hold});
      if (m_hold) begin
        chk("rnd_frame", out_frame, m_frame);
        chk("rnd_count", {28'd0, out_count}, m_words.size());
      end
      if (prev_stall) chk("rnd_stable", out_frame, prev_frame);
      prev_stall = out_valid && !out_ready;
      prev_frame = out_frame;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          m_words.delete();
          frames++;
        end
      end else begin
        if (in_valid) m_words.push_back(in_data);
        if (m_words.size() == N || (flush && m_words.size() > 0)) m_hold = 1'b1;
      end
      tick();
      cycles++;
    end
    chk("rnd_frames_done", frames, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
